// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, framed byte and status strobes out.
interface uart_rx_if;
  logic       serial_in;
  logic [7:0] uart_out;
  logic       uart_out_valid;
  logic       frame_error;
  logic       rx_busy;

  modport master (
    input  serial_in,
    output uart_out, uart_out_valid, frame_error, rx_busy
  );

  modport slave (
    output serial_in,
    input  uart_out, uart_out_valid, frame_error, rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a bit-period counter, one-cycle
// valid / frame-error strobes, BREAK state to swallow a held-low line.
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic     clk,
  input  logic     n_rst,
  uart_rx_if.master rx
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [3:0] {
    IDLE, START,
    DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6, DATA7,
    STOP, BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shift, out_q;
  logic [1:0]       sync;
  logic             rx_s, cnt_end, sample, good, bad, valid_q, ferr_q;
  logic [2:0]       bit_idx;

  assign rx_s    = sync[1];
  assign cnt_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_idx = 3'(state - DATA0);

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      // Half a bit in: a low line confirms the start bit and aligns us to mid-bit.
      START: if (cnt == CNT_W'(HALF_BIT - 1)) state_nxt = rx_s ? IDLE : DATA0;
      DATA0, DATA1, DATA2, DATA3, DATA4, DATA5, DATA6: if (cnt_end) begin
        sample    = 1'b1;
        state_nxt = state_t'(state + 4'd1);
      end
      DATA7: if (cnt_end) begin
        sample    = 1'b1;
        state_nxt = STOP;
      end
      STOP: if (cnt_end) begin
        if (rx_s) begin
          good      = 1'b1;
          state_nxt = IDLE;
        end else begin
          bad       = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (state_nxt != state || cnt_end) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      sync    <= 2'b11;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync    <= {sync[0], rx.serial_in};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_q <= good;
      ferr_q  <= bad;
      if (sample) shift[bit_idx] <= rx_s;
      if (good)   out_q <= shift;
    end
  end

  assign rx.uart_out       = out_q;
  assign rx.uart_out_valid = valid_q;
  assign rx.frame_error    = ferr_q;
  assign rx.rx_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: a behavioural serializer pushes expected
// strobes; a negedge monitor pops and checks kind, byte and latency.
module tb_uart_rx;
  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int CPB        = 16;
  localparam int HALF       = 8;
  // cycles from the drive of the start edge to the strobe being visible
  localparam int LAT        = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus();
  initial bus.serial_in = 1'b1;

  uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx    (bus.master)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serialize one frame; stop=0 leaves the line low afterwards.
  task automatic send(input logic [7:0] d, input bit stop);
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : last_good;
    e.t0   = cyc;
    q.push_back(e);
    if (stop) last_good = d;
    bus.serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = d[i];
      tick(CPB);
    end
    bus.serial_in = stop;
    tick(CPB);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (n_rst === 1'b1 && (bus.uart_out_valid || bus.frame_error)) begin
      if (bus.uart_out_valid && bus.frame_error) check("both_strobes", 1, 0);
      if (q.size() == 0) begin
        check("unexpected_strobe", {bus.uart_out_valid, bus.frame_error}, 0);
      end else begin
        e = q.pop_front();
        check(e.err ? "ferr_kind" : "valid_kind", bus.frame_error, e.err);
        check("uart_out", bus.uart_out, e.data);
        check("latency", cyc - e.t0, LAT);
      end
    end
  end

  initial begin
    logic [7:0] b;
    tick(3);
    check("rst_uart_out", bus.uart_out, 8'h00);
    check("rst_valid", bus.uart_out_valid, 0);
    check("rst_ferr", bus.frame_error, 0);
    check("rst_busy", bus.rx_busy, 0);
    n_rst = 1'b1;
    tick(2 * CPB);

    // single frame, then back-to-back pair
    send(8'hA5, 1'b1);
    tick(2 * CPB);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(2 * CPB);
    check("idle_after_b2b", bus.rx_busy, 0);

    // glitch shorter than half a bit is rejected
    bus.serial_in = 1'b0;
    tick(5);
    bus.serial_in = 1'b1;
    check("glitch_busy", bus.rx_busy, 1);
    tick(HALF + 4);
    check("glitch_idle", bus.rx_busy, 0);
    tick(CPB);

    // bad stop bit with line held low: one frame_error, BREAK until line high
    send(8'h55, 1'b0);
    tick(3 * CPB);
    check("break_busy", bus.rx_busy, 1);
    bus.serial_in = 1'b1;
    tick(4);
    check("break_exit", bus.rx_busy, 0);
    check("ferr_held_out", bus.uart_out, 8'hFF);
    tick(2 * CPB);

    // reset in the middle of DATA3
    b = 8'hA7;
    bus.serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      bus.serial_in = b[i];
      tick(CPB);
    end
    bus.serial_in = b[3];
    tick(HALF);
    check("mid_frame_busy", bus.rx_busy, 1);
    bus.serial_in = 1'b1;
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    last_good = 8'h00;
    check("mid_rst_uart_out", bus.uart_out, 8'h00);
    check("mid_rst_valid", bus.uart_out_valid, 0);
    check("mid_rst_ferr", bus.frame_error, 0);
    check("mid_rst_busy", bus.rx_busy, 0);
    tick(2 * CPB);
    send(8'h3C, 1'b1);
    tick(CPB);

    // random back-to-back loopback
    for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 255)), 1'b1);

    for (int i = 0; i < LAT + 20 && q.size() != 0; i++) tick(1);
    check("scoreboard_drained", q.size(), 0);
    check("final_idle", bus.rx_busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
